// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential signed 32-bit divider: state encodings
// and iteration/latency constants.
package div32_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX_Q = 3'd4,
    S_FIX_R = 3'd5,
    S_DONE  = 3'd6
  } div_state_e;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = 37;

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

endpackage

// File: rtl/div32_seq_add32.sv
// 32-bit ripple-free behavioural adder with carry in/out, shared by every
// divider phase.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle signed restoring divider; one shared adder performs negation,
// trial subtraction and sign fix-up. Quotient feeds LO, remainder feeds HI.
module div32_seq
  import div32_seq_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output div_state_e  state
);

  // Handshake: start is accepted only in IDLE or DONE (busy=0). done is a
  // one-cycle pulse; results and div_by_zero hold until the next accepted start.

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, b_q, q_q, r_q, m_q;
  logic        sq_q, sr_q;

  logic [31:0] add_a, add_b, add_sum, rs;
  logic        add_cin, add_cout;
  logic        accept;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign rs     = {r_q[30:0], q_q[31]};
  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (divisor == 32'd0) ? S_DONE : S_NEG_A;
        else        state_d = S_IDLE;
      end
      S_NEG_A: state_d = S_NEG_B;
      S_NEG_B: state_d = S_ITER;
      S_ITER:  if (cnt_q == 5'd0) state_d = S_FIX_Q;
      S_FIX_Q: state_d = S_FIX_R;
      S_FIX_R: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand mux: exactly one adder operation per state.
  always_comb begin
    add_a   = a_q;
    add_b   = 32'd0;
    add_cin = 1'b0;
    case (state_q)
      S_NEG_A: if (a_q[31]) begin add_a = ~a_q; add_cin = 1'b1; end
      S_NEG_B: begin
        add_a = b_q[31] ? ~b_q : b_q;
        add_cin = b_q[31];
      end
      S_ITER:  begin add_a = rs;   add_b = ~m_q; add_cin = 1'b1; end
      S_FIX_Q: begin add_a = ~q_q; add_cin = 1'b1; end
      S_FIX_R: begin add_a = ~r_q; add_cin = 1'b1; end
      default: ;
    endcase
  end

  add32 u_add (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (add_cin),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q       <= 5'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      q_q         <= 32'd0;
      r_q         <= 32'd0;
      m_q         <= 32'd0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        a_q         <= dividend;
        b_q         <= divisor;
        sq_q        <= dividend[31] ^ divisor[31];
        sr_q        <= dividend[31];
        div_by_zero <= (divisor == 32'd0);
        if (divisor == 32'd0) begin
          quotient  <= 32'd0;
          remainder <= dividend;
        end
      end
      case (state_q)
        S_NEG_A: begin
          q_q <= add_sum;
          r_q <= 32'd0;
        end
        S_NEG_B: begin
          m_q   <= add_sum;
          cnt_q <= LAST_ITER;
        end
        S_ITER: begin
          // carry_out=1 means Rs >= |B|: keep the difference.
          if (add_cout) begin
            r_q <= add_sum;
            q_q <= {q_q[30:0], 1'b1};
          end else begin
            r_q <= rs;
            q_q <= {q_q[30:0], 1'b0};
          end
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        S_FIX_Q: if (sq_q) q_q <= add_sum;
        S_FIX_R: begin
          quotient  <= q_q;
          remainder <= sr_q ? add_sum : r_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random checks of div32_seq against a magnitude-arithmetic
// reference of signed truncating division.
module tb_div32_seq;
  import div32_seq_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  div_state_e  state;

  int n_vec  = 0;
  int n_fail = 0;

  div32_seq dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes exactly in 64-bit, then apply sign rules.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, ma, mb, mq, mr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
    end else begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      mq = ma / mb;
      mr = ma % mb;
      if ((sa < 0) != (sb < 0)) mq = -mq;
      if (sa < 0) mr = -mr;
      q = mq[31:0];
      r = mr[31:0];
    end
  endtask

  // Called #1 after a posedge; returns in cycle 1 of the operation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc, output bit busy_ok);
    cyc = cyc0;
    busy_ok = 1'b1;
    while (!done && cyc < 80) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int cyc0);
    int cyc;
    bit busy_ok;
    logic [31:0] eq, er;
    wait_done(cyc0, cyc, busy_ok);
    ref_div(a, b, eq, er);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " latency"}, cyc, (b == 32'd0) ? 32'd1 : 32'(DIV_LATENCY));
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, b == 32'd0});
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst state", {29'd0, state}, {29'd0, S_IDLE});
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;

    issue(32'd100, 32'd7);            check_op("100/7", 32'd100, 32'd7, 1);
    chk("100/7 q const", quotient, 32'd14);
    chk("100/7 r const", remainder, 32'd2);
    @(posedge clock); #1;
    chk("done pulse", {31'd0, done}, 32'd0);
    issue(-32'sd100, 32'd7);          check_op("-100/7", -32'sd100, 32'd7, 1);
    chk("-100/7 q const", quotient, 32'hFFFFFFF2);
    issue(32'd7, -32'sd2);            check_op("7/-2", 32'd7, -32'sd2, 1);
    chk("7/-2 q const", quotient, 32'hFFFFFFFD);
    issue(32'h80000000, 32'hFFFFFFFF); check_op("ovf", 32'h80000000, 32'hFFFFFFFF, 1);
    chk("ovf q const", quotient, 32'h80000000);
    issue(32'h80000000, 32'd2);       check_op("min/2", 32'h80000000, 32'd2, 1);
    chk("min/2 q const", quotient, 32'hC0000000);
    issue(32'd5, 32'd0);              check_op("5/0", 32'd5, 32'd0, 1);
    chk("5/0 r const", remainder, 32'd5);
    issue(32'd100, 32'd7);            check_op("clr dbz", 32'd100, 32'd7, 1);

    // New start in cycle 10 must be ignored
    issue(32'd100, 32'd7);
    repeat (9) begin @(posedge clock); #1; end
    issue(32'd55, 32'd3);
    check_op("ign start", 32'd100, 32'd7, 11);

    // Back-to-back: start held in the done cycle
    issue(32'd9, 32'd3);              check_op("b2b", 32'd9, 32'd3, 1);
    issue(32'd100, 32'd7);            check_op("b2b 2", 32'd100, 32'd7, 1);

    // Clear mid-operation aborts
    issue(32'd5, 32'd0);              check_op("pre clr", 32'd5, 32'd0, 1);
    issue(32'd100, 32'd7);
    repeat (19) begin @(posedge clock); #1; end
    @(negedge clock); clear = 1'b0; #1;
    chk("clr busy", {31'd0, busy}, 32'd0);
    chk("clr done", {31'd0, done}, 32'd0);
    chk("clr quotient", quotient, 32'd0);
    chk("clr remainder", remainder, 32'd0);
    chk("clr dbz", {31'd0, div_by_zero}, 32'd0);
    chk("clr state", {29'd0, state}, {29'd0, S_IDLE});
    @(negedge clock); clear = 1'b1;
    done_seen = 0;
    repeat (50) begin @(posedge clock); #1; if (done) done_seen++; end
    chk("clr no done", done_seen, 32'd0);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = -32'($urandom_range(1, 20));
        2: rb = (i % 6 == 0) ? 32'd0 : $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      issue(ra, rb);
      check_op("rand", ra, rb, 1);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
